ahb_iop_master: RTL



---
 rtl/ahb_pkg.sv | 43 ++++
 rtl/ahb_lane_steer.sv | 52 +++++
 rtl/ahb_iop_master.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the initiator state encoding.
//   HTRANS_*  : transfer type codes (only IDLE and NONSEQ are ever issued)
//   HSIZE_*   : transfer size codes
//   HBURST_*  : burst type codes
//   RSP_*     : response status returned on the command side
//   iop_state_e : initiator FSM states
//   is_misaligned : command legality test used before any bus activity
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] RSP_OK       = 2'b00;
  localparam logic [1:0] RSP_BUSERR   = 2'b01;
  localparam logic [1:0] RSP_MISALIGN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } iop_state_e;

  // Size 3 is illegal; halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr_lo[0];
      2'd2:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Combinational byte-lane steering between right-justified command data and
// the 32-bit AHB data buses.
//   BE          : 0 little endian, 1 big endian (byte-invariant)
//   addr_lo     : in  address bits [1:0] of the transfer
//   size        : in  0 byte, 1 halfword, 2 word (3 yields zero)
//   wdata_in    : in  right-justified write data
//   wdata_lanes : out write data placed on its lanes, other lanes zero
//   rdata_lanes : in  raw HRDATA
//   rdata_out   : out selected lanes, right-justified and zero-extended
module ahb_lane_steer #(
  parameter bit BE = 1'b0
) (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata_in,
  output logic [31:0] wdata_lanes,
  input  logic [31:0] rdata_lanes,
  output logic [31:0] rdata_out
);

  logic [1:0]  byte_lane;
  logic        half_hi;
  logic [31:0] rshift;

  always_comb begin
    // Big endian mirrors the lane index: byte 0 lives in bits [31:24].
    byte_lane   = BE ? ~addr_lo : addr_lo;
    half_hi     = BE ? ~addr_lo[1] : addr_lo[1];
    rshift      = rdata_lanes >> {byte_lane, 3'b000};
    wdata_lanes = '0;
    rdata_out   = '0;
    case (size)
      2'd0: begin
        wdata_lanes = {24'h0, wdata_in[7:0]} << {byte_lane, 3'b000};
        rdata_out   = {24'h0, rshift[7:0]};
      end
      2'd1: begin
        wdata_lanes = half_hi ? {wdata_in[15:0], 16'h0} : {16'h0, wdata_in[15:0]};
        rdata_out   = half_hi ? {16'h0, rdata_lanes[31:16]} : {16'h0, rdata_lanes[15:0]};
      end
      2'd2: begin
        wdata_lanes = wdata_in;
        rdata_out   = rdata_lanes;
      end
      default: begin
        wdata_lanes = '0;
        rdata_out   = '0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_iop_master.sv
// Single-transfer AHB-Lite initiator: one NONSEQ SINGLE transfer per command.
//   HCLK, HRESET            : clock, synchronous active-high reset
//   cmd_*                   : command channel (addr, write, size, wdata)
//   rsp_*                   : response channel (rdata, err)
//   HADDR..HWDATA           : AHB-Lite master outputs (all registered)
//   HRDATA, HREADY, HRESP   : AHB-Lite slave returns
//   dbg_state               : current FSM state (iop_state_e encoding)
// Handshake: a transfer on either channel happens on a rising edge where
// valid and ready are both high; the source holds its payload stable while
// valid is high and ready is low, and valid never drops without a transfer.
module ahb_iop_master
  import ahb_pkg::*;
#(
  parameter bit         BE          = 1'b0,
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [1:0]  dbg_state
);

  iop_state_e  state;
  logic [31:0] wdata_q;
  logic [31:0] wdata_steered;
  logic [31:0] rdata_extracted;

  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VALUE;
  assign HMASTLOCK = 1'b0;
  assign dbg_state = state;

  // Steering works from the registered address/size already on the bus.
  ahb_lane_steer #(.BE(BE)) u_steer (
    .addr_lo     (HADDR[1:0]),
    .size        (HSIZE[1:0]),
    .wdata_in    (wdata_q),
    .wdata_lanes (wdata_steered),
    .rdata_lanes (HRDATA),
    .rdata_out   (rdata_extracted)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= RSP_OK;
      HTRANS    <= HTRANS_IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= HSIZE_BYTE;
      HWDATA    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (is_misaligned(cmd_size, cmd_addr[1:0])) begin
              // Rejected locally: bus outputs are left untouched.
              rsp_valid <= 1'b1;
              rsp_err   <= RSP_MISALIGN;
              rsp_rdata <= '0;
              state     <= ST_RESP;
            end else begin
              HADDR   <= cmd_addr;
              HWRITE  <= cmd_write;
              HSIZE   <= {1'b0, cmd_size};
              HTRANS  <= HTRANS_NONSEQ;
              wdata_q <= cmd_wdata;
              state   <= ST_ADDR;
            end
          end else begin
            // Also raises ready on the first cycle after reset.
            cmd_ready <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            HWDATA <= HWRITE ? wdata_steered : '0;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          // The first error cycle has HREADY low and is simply waited out.
          if (HREADY) begin
            HWDATA    <= '0;
            rsp_valid <= 1'b1;
            if (HRESP) begin
              rsp_err   <= RSP_BUSERR;
              rsp_rdata <= '0;
            end else begin
              rsp_err   <= RSP_OK;
              rsp_rdata <= HWRITE ? '0 : rdata_extracted;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= RSP_OK;
            rsp_rdata <= '0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
